// File: rtl/vocab_writer.sv
// vocab_writer: stores a session of packed words byte-serially into SRAM, 0x00 after each word plus a closing 0x00.
// Latency: a word of length L costs one accept cycle plus L+1 write cycles; the end marker costs one more write cycle.
// Backpressure: word_ready is high only in ACCEPT; words are held off while writing and for good after a rejection.
module vocab_writer #(
  parameter int ADDR_WIDTH  = 4,
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cs,
  input  logic [ADDR_WIDTH-1:0]             start_addr,
  input  logic [ADDR_WIDTH-1:0]             end_addr,
  input  logic                              word_valid,
  input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
  output logic                              word_ready,
  input  logic                              finish,
  output logic                              mem_cs,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_din,
  output logic [ADDR_WIDTH:0]               wr_addr,
  output logic [ADDR_WIDTH:0]               word_count,
  output logic                              overflow,
  output logic                              done
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int LW  = $clog2(WORD_LENGTH + 1);
  localparam int WW  = WORD_LENGTH * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    TERM,
    FINAL,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [WW-1:0]          word_q;
  logic [LW-1:0]          len_q;
  logic [LW-1:0]          idx;
  logic                   fin_pend;
  logic [LW-1:0]          word_len;
  logic                   hit_zero;
  logic [AW1-1:0]         need_end;
  logic                   fits;
  logic                   bad_window;
  logic [DATA_WIDTH-1:0]  cur_char;

  // Word length = number of leading non-zero characters; the first 0x00 ends the word.
  always_comb begin
    word_len = '0;
    hit_zero = 1'b0;
    for (int i = 0; i < WORD_LENGTH; i++) begin
      if (!hit_zero && (word[(WORD_LENGTH-1-i)*DATA_WIDTH +: DATA_WIDTH] != '0)) begin
        word_len = word_len + LW'(1);
      end else begin
        hit_zero = 1'b1;
      end
    end
  end

  // Space check on ADDR_WIDTH+1 bits: word chars, its terminator and the end marker must all fit.
  assign need_end   = wr_addr + AW1'(word_len) + AW1'(1);
  assign fits       = (need_end <= {1'b0, end_addr});
  assign bad_window = (start_addr > end_addr);

  // Select the character currently being written from the latched word.
  always_comb begin
    cur_char = '0;
    for (int i = 0; i < WORD_LENGTH; i++) begin
      if (idx == LW'(i)) begin
        cur_char = word_q[(WORD_LENGTH-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; dropping cs overrides everything and kills any write this cycle.
  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (cs) begin
          state_nxt = bad_window ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        word_ready = 1'b1;
        if (word_valid) begin
          if (word_len == '0) begin
            state_nxt = finish ? FINAL : ACCEPT;
          end else if (fits) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = FINAL;
          end
        end else if (finish) begin
          state_nxt = FINAL;
        end
      end
      WRITE: begin
        mem_we   = 1'b1;
        mem_addr = wr_addr[ADDR_WIDTH-1:0];
        mem_din  = cur_char;
        if (idx == len_q - LW'(1)) begin
          state_nxt = TERM;
        end
      end
      TERM: begin
        mem_we    = 1'b1;
        mem_addr  = wr_addr[ADDR_WIDTH-1:0];
        state_nxt = (fin_pend || finish) ? FINAL : ACCEPT;
      end
      FINAL: begin
        mem_we    = 1'b1;
        mem_addr  = wr_addr[ADDR_WIDTH-1:0];
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!cs) begin
      state_nxt  = IDLE;
      word_ready = 1'b0;
      mem_we     = 1'b0;
      done       = 1'b0;
    end
  end

  assign mem_cs = mem_we;

  // Session datapath: address/count/overflow bookkeeping and word latch; values hold while cs is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr    <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      word_q     <= '0;
      len_q      <= '0;
      idx        <= '0;
      fin_pend   <= 1'b0;
    end else if (!cs) begin
      fin_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wr_addr    <= {1'b0, start_addr};
          word_count <= '0;
          overflow   <= bad_window;
          fin_pend   <= 1'b0;
        end
        ACCEPT: begin
          if (word_valid) begin
            word_q   <= word;
            len_q    <= word_len;
            idx      <= '0;
            fin_pend <= finish;
            if ((word_len != '0) && !fits) begin
              overflow <= 1'b1;
            end
          end
        end
        WRITE: begin
          wr_addr <= wr_addr + AW1'(1);
          idx     <= idx + LW'(1);
          if (finish) begin
            fin_pend <= 1'b1;
          end
        end
        TERM: begin
          wr_addr    <= wr_addr + AW1'(1);
          word_count <= word_count + AW1'(1);
          if (finish) begin
            fin_pend <= 1'b1;
          end
        end
        FINAL: begin
          wr_addr <= wr_addr + AW1'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
